nettlp_cmd_tx: RTL and testbench

Packs NetTLP command responses from the command block's output FIFO into UDP payload frames for the Ethernet transmit path. It coalesces up to MAX_CMDS responses per frame, bounded by a hold-off timer. It sits between the `fifo_cmd_o_*` read side of `nettlp_cmd` and the UDP TX encapsulator. The encapsulator adds the Ethernet, IP and UDP headers.

---
 rtl/nettlp_cmd_pkg.sv | 45 ++++
 rtl/nettlp_cmd_tx_buf.sv | 49 ++++
 rtl/nettlp_cmd_tx.sv | 189 ++++++++++++++++++
 tb/tb_nettlp_cmd_tx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nettlp_cmd_pkg.sv
// nettlp_cmd_pkg
// Shared types and constants for the NetTLP command block and its
// response transmitter.
//   FIFO_NETTLP_CMD_T      - 128-bit response entry read from the command
//                            output FIFO.
//   NETTLP_CMD_TX_STATE_T  - state encoding of the response transmitter.
//   NETTLP_CMD_MAGIC/VER   - constants placed in every response frame header.
//   nettlp_cmd_tx_hdr      - builds the 64-bit frame header beat.
//   nettlp_cmd_tx_beat_a   - builds the first payload beat of one response.
package nettlp_cmd_pkg;

    localparam int CMD_W = 128;
    localparam int CNT_W = 4;

    localparam logic [15:0] NETTLP_CMD_MAGIC = 16'h4E43;
    localparam logic [7:0]  NETTLP_CMD_VER   = 8'h01;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  status;
        logic [15:0] seq;
        logic [31:0] addr;
        logic [63:0] data;
    } FIFO_NETTLP_CMD_T;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_GATHER = 3'd1,
        TX_HDR    = 3'd2,
        TX_CMD_A  = 3'd3,
        TX_CMD_B  = 3'd4
    } NETTLP_CMD_TX_STATE_T;

    // Header beat: magic, version, reserved nibble, response count, frame number.
    function automatic logic [63:0] nettlp_cmd_tx_hdr(input logic [3:0]  count,
                                                       input logic [31:0] frame_no);
        return {NETTLP_CMD_MAGIC, NETTLP_CMD_VER, 4'h0, count, frame_no};
    endfunction

    // First beat of a response: everything except the 64-bit data word.
    function automatic logic [63:0] nettlp_cmd_tx_beat_a(input FIFO_NETTLP_CMD_T e);
        return {e.opcode, e.status, e.seq, e.addr};
    endfunction

endpackage

// File: rtl/nettlp_cmd_tx_buf.sv
// nettlp_cmd_tx_buf
// Holding buffer for the responses coalesced into one frame.
//   clk, rst  - clock and synchronous active-high reset (clears all entries).
//   we        - write strobe; wdata is stored at waddr.
//   waddr     - write slot (0..MAX_CMDS-1); out-of-range writes are dropped.
//   wdata     - 128-bit response entry.
//   idx       - combinational read slot; out-of-range reads return zero.
//   rdata     - entry stored at idx.
import nettlp_cmd_pkg::*;

module nettlp_cmd_tx_buf #(
    parameter int MAX_CMDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [CNT_W-1:0]   waddr,
    input  logic [CMD_W-1:0]   wdata,
    input  logic [CNT_W-1:0]   idx,
    output logic [CMD_W-1:0]   rdata
);

    localparam int AW = (MAX_CMDS > 1) ? $clog2(MAX_CMDS) : 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_CMDS);

    logic [CMD_W-1:0] mem_r [MAX_CMDS];

    // Storage array: cleared on reset, written one entry per capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_CMDS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && (waddr < DEPTH)) begin
            mem_r[waddr[AW-1:0]] <= wdata;
        end
    end

    // Combinational read port with a guard against slots past the end.
    always_comb begin
        rdata = '0;
        if (idx < DEPTH) begin
            rdata = mem_r[idx[AW-1:0]];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/nettlp_cmd_tx.sv
// nettlp_cmd_tx
// Drains NetTLP command responses from the command output FIFO and packs
// up to MAX_CMDS of them into one UDP payload frame (header beat followed
// by two beats per response). A hold-off timer closes a partially filled
// frame after HOLDOFF idle cycles.
//   clk, rst           - clock and synchronous active-high reset.
//   fifo_cmd_o_rd_en   - FIFO read strobe (data arrives the next cycle).
//   fifo_cmd_o_empty   - FIFO empty flag.
//   fifo_cmd_o_dout    - FIFO response entry (FIFO_NETTLP_CMD_T layout).
//   tx_tdata/tkeep/tvalid/tready/tlast - AXI-Stream payload output.
//   frame_cnt          - frames fully sent (wraps).
//   cmd_cnt            - responses fully sent (wraps).
import nettlp_cmd_pkg::*;

module nettlp_cmd_tx #(
    parameter int MAX_CMDS = 4,
    parameter int HOLDOFF  = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          fifo_cmd_o_rd_en,
    input  logic          fifo_cmd_o_empty,
    input  logic [127:0]  fifo_cmd_o_dout,
    output logic [63:0]   tx_tdata,
    output logic [7:0]    tx_tkeep,
    output logic          tx_tvalid,
    input  logic          tx_tready,
    output logic          tx_tlast,
    output logic [31:0]   frame_cnt,
    output logic [31:0]   cmd_cnt
);

    // Timer only has to hold 0..HOLDOFF-1.
    localparam int TW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CMDS);

    NETTLP_CMD_TX_STATE_T state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     idx_r;
    logic [TW-1:0]        timer_r;
    logic                 pending_r;

    logic                 rd_en_s;
    logic                 room_s;
    logic                 handshake_s;
    logic [CNT_W-1:0]     rd_idx_s;
    logic [CMD_W-1:0]     rdata_s;
    FIFO_NETTLP_CMD_T     rd_entry_s;

    // Reads already issued but not yet captured still claim a buffer slot.
    assign room_s = ({1'b0, cnt_r} + {{CNT_W{1'b0}}, pending_r}) < {1'b0, MAX_CNT};

    assign handshake_s      = tx_tvalid && tx_tready;
    assign fifo_cmd_o_rd_en = rd_en_s;
    assign rd_entry_s       = FIFO_NETTLP_CMD_T'(rdata_s);

    // FIFO read strobe: combinational so the read issues in the same cycle
    // that the FIFO shows data; never asserted while transmitting.
    always_comb begin
        rd_en_s = 1'b0;
        case (state_r)
            TX_IDLE:   rd_en_s = !fifo_cmd_o_empty;
            TX_GATHER: rd_en_s = !fifo_cmd_o_empty && room_s;
            default:   rd_en_s = 1'b0;
        endcase
    end

    // Buffer read slot: CMD_B looks one entry ahead to preload the next beat A.
    always_comb begin
        rd_idx_s = idx_r;
        case (state_r)
            TX_HDR:   rd_idx_s = '0;
            TX_CMD_B: rd_idx_s = idx_r + 4'd1;
            default:  rd_idx_s = idx_r;
        endcase
    end

    nettlp_cmd_tx_buf #(
        .MAX_CMDS (MAX_CMDS)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (pending_r),
        .waddr (cnt_r),
        .wdata (fifo_cmd_o_dout),
        .idx   (rd_idx_s),
        .rdata (rdata_s)
    );

    // Main FSM with hold-off timer, counters and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= TX_IDLE;
            cnt_r     <= '0;
            idx_r     <= '0;
            timer_r   <= '0;
            pending_r <= 1'b0;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            tx_tdata  <= 64'h0;
            tx_tkeep  <= 8'h00;
            frame_cnt <= 32'h0;
            cmd_cnt   <= 32'h0;
        end else begin
            pending_r <= rd_en_s;
            case (state_r)
                TX_IDLE: begin
                    timer_r <= '0;
                    if (rd_en_s) begin
                        state_r <= TX_GATHER;
                    end
                end

                TX_GATHER: begin
                    if (pending_r) begin
                        // Capture cycle: FIFO dout belongs to last cycle's read.
                        cnt_r   <= cnt_r + 4'd1;
                        timer_r <= '0;
                        if ((cnt_r + 4'd1) == MAX_CNT) begin
                            // Buffer full: send without waiting for the hold-off.
                            state_r   <= TX_HDR;
                            tx_tvalid <= 1'b1;
                            tx_tkeep  <= 8'hFF;
                            tx_tlast  <= 1'b0;
                            tx_tdata  <= nettlp_cmd_tx_hdr(MAX_CNT, frame_cnt);
                        end
                    end else if (!rd_en_s) begin
                        // Idle cycle: advance the hold-off timer.
                        timer_r <= timer_r + TW'(1);
                        if ((cnt_r == MAX_CNT) || (timer_r == TIMER_LAST)) begin
                            state_r   <= TX_HDR;
                            tx_tvalid <= 1'b1;
                            tx_tkeep  <= 8'hFF;
                            tx_tlast  <= 1'b0;
                            tx_tdata  <= nettlp_cmd_tx_hdr(cnt_r, frame_cnt);
                        end
                    end
                end

                TX_HDR: begin
                    if (handshake_s) begin
                        idx_r    <= '0;
                        tx_tdata <= nettlp_cmd_tx_beat_a(rd_entry_s);
                        tx_tlast <= 1'b0;
                        state_r  <= TX_CMD_A;
                    end
                end

                TX_CMD_A: begin
                    if (handshake_s) begin
                        tx_tdata <= rd_entry_s.data;
                        tx_tlast <= (idx_r == (cnt_r - 4'd1));
                        state_r  <= TX_CMD_B;
                    end
                end

                TX_CMD_B: begin
                    if (handshake_s) begin
                        idx_r   <= idx_r + 4'd1;
                        cmd_cnt <= cmd_cnt + 32'd1;
                        if (idx_r == (cnt_r - 4'd1)) begin
                            frame_cnt <= frame_cnt + 32'd1;
                            cnt_r     <= '0;
                            timer_r   <= '0;
                            tx_tvalid <= 1'b0;
                            tx_tlast  <= 1'b0;
                            tx_tkeep  <= 8'h00;
                            tx_tdata  <= 64'h0;
                            state_r   <= TX_IDLE;
                        end else begin
                            tx_tdata <= nettlp_cmd_tx_beat_a(rd_entry_s);
                            tx_tlast <= 1'b0;
                            state_r  <= TX_CMD_A;
                        end
                    end
                end

                default: begin
                    state_r   <= TX_IDLE;
                    tx_tvalid <= 1'b0;
                    tx_tlast  <= 1'b0;
                    tx_tkeep  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nettlp_cmd_tx.sv
// tb_nettlp_cmd_tx
// Self-checking bench for nettlp_cmd_tx. A queue-based FIFO model feeds the
// design; a monitor logs read strobes and accepted beats; a reference model
// chunks pushed responses into frames and predicts every beat and counter.
`timescale 1ns/1ps

module tb_nettlp_cmd_tx;
    import nettlp_cmd_pkg::*;

    localparam int MAX_CMDS = 4;
    localparam int HOLDOFF  = 16;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rd_en;
    logic          fifo_empty = 1'b1;
    logic [127:0]  fifo_dout  = '0;
    logic [63:0]   tx_tdata;
    logic [7:0]    tx_tkeep;
    logic          tx_tvalid;
    logic          tx_tready;
    logic          tx_tlast;
    logic [31:0]   frame_cnt;
    logic [31:0]   cmd_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    FIFO_NETTLP_CMD_T fifo_q[$];
    FIFO_NETTLP_CMD_T model_q[$];
    beat_t            obs_q[$];
    beat_t            exp_q[$];
    int               rd_cyc_q[$];
    logic [31:0]      model_frames;
    logic [31:0]      model_cmds;

    nettlp_cmd_tx #(.MAX_CMDS(MAX_CMDS), .HOLDOFF(HOLDOFF)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_cmd_o_rd_en (fifo_rd_en),
        .fifo_cmd_o_empty (fifo_empty),
        .fifo_cmd_o_dout  (fifo_dout),
        .tx_tdata         (tx_tdata),
        .tx_tkeep         (tx_tkeep),
        .tx_tvalid        (tx_tvalid),
        .tx_tready        (tx_tready),
        .tx_tlast         (tx_tlast),
        .frame_cnt        (frame_cnt),
        .cmd_cnt          (cmd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Standard FIFO model: dout valid the cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Downstream ready pattern, changed just after each active edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = ~tx_tready;
            default: tx_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: log read strobes and beats that will be accepted at the next edge.
    always @(negedge clk) begin
        if (fifo_rd_en) rd_cyc_q.push_back(cyc);
        if (tx_tvalid && tx_tready) obs_q.push_back('{tx_tdata, tx_tlast, cyc});
    end

    task automatic push_resp(input FIFO_NETTLP_CMD_T e);
        fifo_q.push_back(e);
        model_q.push_back(e);
    endtask

    function automatic FIFO_NETTLP_CMD_T rand_resp();
        FIFO_NETTLP_CMD_T e;
        e = {$urandom, $urandom, $urandom, $urandom};
        return e;
    endfunction

    // Reference model: responses queued together leave in frames of at most MAX_CMDS.
    task automatic build_expected();
        int n;
        FIFO_NETTLP_CMD_T e;
        while (model_q.size() > 0) begin
            n = (model_q.size() > MAX_CMDS) ? MAX_CMDS : model_q.size();
            exp_q.push_back('{{16'h4E43, 8'h01, 4'h0, 4'(n), model_frames}, 1'b0, 0});
            for (int k = 0; k < n; k++) begin
                e = model_q.pop_front();
                exp_q.push_back('{{e.opcode, e.status, e.seq, e.addr}, 1'b0, 0});
                exp_q.push_back('{e.data, (k == n - 1), 0});
                model_cmds = model_cmds + 32'd1;
            end
            model_frames = model_frames + 32'd1;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        obs_q.delete();
        exp_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (tx_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tx_tvalid); else n_pass++;
        n_total++; if (tx_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", tx_tlast); else n_pass++;
        n_total++; if (tx_tdata !== 64'h0) $display("FAIL reset_tdata: got %h want 0", tx_tdata); else n_pass++;
        n_total++; if (tx_tkeep !== 8'h00) $display("FAIL reset_tkeep: got %h want 00", tx_tkeep); else n_pass++;
        n_total++; if (frame_cnt !== 32'h0) $display("FAIL reset_frame_cnt: got %h want 0", frame_cnt); else n_pass++;
        n_total++; if (cmd_cnt !== 32'h0) $display("FAIL reset_cmd_cnt: got %h want 0", cmd_cnt); else n_pass++;
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
        rst = 1'b0;
        model_frames = 32'h0;
        model_cmds   = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        FIFO_NETTLP_CMD_T e;
        ready_mode = 0;
        clear_logs();
        e = '{opcode: 8'h01, status: 8'h00, seq: 16'h0005, addr: 32'h0000_1000, data: 64'h0000_0000_DEAD_BEEF};
        push_resp(e);
        build_expected();
        wait_beats(3, 200, ok);
        n_total++; if (!ok) $display("FAIL single_timeout: got %0d beats want 3", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size()) $display("FAIL single_beat%0d: missing, want %h", i, exp_q[i].data);
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                $display("FAIL single_beat%0d: got %h last=%b want %h last=%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        if (ok && rd_cyc_q.size() > 0) begin
            n_total++;
            if (obs_q[0].cyc - rd_cyc_q[0] != HOLDOFF + 2)
                $display("FAIL single_hdr_latency: got %0d want %0d", obs_q[0].cyc - rd_cyc_q[0], HOLDOFF + 2);
            else n_pass++;
            n_total++;
            if (obs_q[2].cyc - rd_cyc_q[0] != HOLDOFF + 4)
                $display("FAIL single_tlast_latency: got %0d want %0d", obs_q[2].cyc - rd_cyc_q[0], HOLDOFF + 4);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++; if (frame_cnt !== model_frames) $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, model_frames); else n_pass++;
        n_total++; if (cmd_cnt !== model_cmds) $display("FAIL single_cmd_cnt: got %0d want %0d", cmd_cnt, model_cmds); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        ready_mode = 0;
        clear_logs();
        for (int i = 0; i < 6; i++) push_resp(rand_resp());
        build_expected();
        wait_beats(exp_q.size(), 400, ok);
        n_total++; if (!ok) $display("FAIL b2b_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size()) $display("FAIL b2b_beat%0d: missing, want %h", i, exp_q[i].data);
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                $display("FAIL b2b_beat%0d: got %h last=%b want %h last=%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        if (ok && rd_cyc_q.size() > 0) begin
            n_total++;
            if (obs_q[0].cyc - rd_cyc_q[0] != MAX_CMDS + 1)
                $display("FAIL b2b_full_hdr_latency: got %0d want %0d", obs_q[0].cyc - rd_cyc_q[0], MAX_CMDS + 1);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++; if (frame_cnt !== model_frames) $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, model_frames); else n_pass++;
        n_total++; if (cmd_cnt !== model_cmds) $display("FAIL b2b_cmd_cnt: got %0d want %0d", cmd_cnt, model_cmds); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] prev_data;
        logic        prev_last;
        bit          prev_stall;
        int          stalls;
        ready_mode = 1;
        clear_logs();
        prev_stall = 1'b0;
        prev_data  = 64'h0;
        prev_last  = 1'b0;
        stalls     = 0;
        for (int i = 0; i < 4; i++) push_resp(rand_resp());
        build_expected();
        for (int c = 0; c < 400 && obs_q.size() < 9; c++) begin
            @(negedge clk); #1;
            if (prev_stall) begin
                n_total++;
                if (tx_tvalid !== 1'b1 || tx_tdata !== prev_data || tx_tlast !== prev_last)
                    $display("FAIL bp_hold: got v=%b %h l=%b want v=1 %h l=%b", tx_tvalid, tx_tdata, tx_tlast, prev_data, prev_last);
                else n_pass++;
            end
            if (tx_tvalid) begin
                n_total++;
                if (tx_tkeep !== 8'hFF) $display("FAIL bp_tkeep: got %h want FF", tx_tkeep); else n_pass++;
            end
            prev_stall = tx_tvalid && !tx_tready;
            if (prev_stall) stalls++;
            prev_data = tx_tdata;
            prev_last = tx_tlast;
        end
        n_total++; if (stalls == 0) $display("FAIL bp_stalls: got 0 stalled cycles want >0"); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++; if (obs_q.size() != 9) $display("FAIL bp_beat_count: got %0d want 9", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size()) $display("FAIL bp_beat%0d: missing, want %h", i, exp_q[i].data);
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                $display("FAIL bp_beat%0d: got %h last=%b want %h last=%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        ready_mode = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timer_restart();
        bit ok;
        ready_mode = 0;
        clear_logs();
        push_resp(rand_resp());
        for (int c = 0; c < 50 && rd_cyc_q.size() == 0; c++) begin
            @(negedge clk); #1;
        end
        n_total++; if (rd_cyc_q.size() == 0) $display("FAIL timer_first_rd: got none want one"); else n_pass++;
        if (rd_cyc_q.size() > 0) begin
            while (cyc < rd_cyc_q[0] + 11) begin
                @(negedge clk); #1;
            end
        end
        push_resp(rand_resp());
        build_expected();
        wait_beats(5, 200, ok);
        n_total++; if (!ok) $display("FAIL timer_timeout: got %0d beats want 5", obs_q.size()); else n_pass++;
        n_total++;
        if (rd_cyc_q.size() != 2) $display("FAIL timer_rd_count: got %0d want 2", rd_cyc_q.size());
        else if (rd_cyc_q[1] - rd_cyc_q[0] != 12) $display("FAIL timer_rd_gap: got %0d want 12", rd_cyc_q[1] - rd_cyc_q[0]);
        else n_pass++;
        if (ok && rd_cyc_q.size() == 2) begin
            n_total++;
            if (obs_q[0].cyc - rd_cyc_q[1] != HOLDOFF + 2)
                $display("FAIL timer_hdr_latency: got %0d want %0d", obs_q[0].cyc - rd_cyc_q[1], HOLDOFF + 2);
            else n_pass++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size()) $display("FAIL timer_beat%0d: missing, want %h", i, exp_q[i].data);
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                $display("FAIL timer_beat%0d: got %h last=%b want %h last=%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        ready_mode = 0;
        clear_logs();
        for (int i = 0; i < 3; i++) push_resp(rand_resp());
        model_q.delete();
        wait_beats(2, 200, ok);
        n_total++; if (!ok) $display("FAIL rstmid_timeout: got %0d beats want 2", obs_q.size()); else n_pass++;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        n_total++; if (tx_tvalid !== 1'b0) $display("FAIL rstmid_tvalid: got %b want 0", tx_tvalid); else n_pass++;
        n_total++; if (frame_cnt !== 32'h0) $display("FAIL rstmid_frame_cnt: got %h want 0", frame_cnt); else n_pass++;
        n_total++; if (cmd_cnt !== 32'h0) $display("FAIL rstmid_cmd_cnt: got %h want 0", cmd_cnt); else n_pass++;
        rst = 1'b0;
        model_frames = 32'h0;
        model_cmds   = 32'h0;
        @(negedge clk); #1;
        clear_logs();
        push_resp(rand_resp());
        build_expected();
        wait_beats(3, 200, ok);
        n_total++; if (!ok) $display("FAIL rstmid_next_timeout: got %0d beats want 3", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size()) $display("FAIL rstmid_beat%0d: missing, want %h", i, exp_q[i].data);
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                $display("FAIL rstmid_beat%0d: got %h last=%b want %h last=%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok;
        ready_mode = 0;
        clear_logs();
        @(negedge clk); #1;
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        model_frames = 32'hFFFF_FFFF;
        push_resp(rand_resp());
        build_expected();
        wait_beats(3, 200, ok);
        n_total++; if (!ok) $display("FAIL wrap_timeout: got %0d beats want 3", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size()) $display("FAIL wrap_beat%0d: missing, want %h", i, exp_q[i].data);
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                $display("FAIL wrap_beat%0d: got %h last=%b want %h last=%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++; if (frame_cnt !== 32'h0) $display("FAIL wrap_frame_cnt: got %h want 0", frame_cnt); else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int n;
        ready_mode = 2;
        for (int r = 0; r < 5; r++) begin
            clear_logs();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) push_resp(rand_resp());
            build_expected();
            wait_beats(exp_q.size(), 3000, ok);
            n_total++; if (!ok) $display("FAIL rand%0d_timeout: got %0d beats want %0d", r, obs_q.size(), exp_q.size()); else n_pass++;
            repeat (8) @(negedge clk);
            n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand%0d_beat_count: got %0d want %0d", r, obs_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_total++;
                if (i >= obs_q.size()) $display("FAIL rand%0d_beat%0d: missing, want %h", r, i, exp_q[i].data);
                else if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
                    $display("FAIL rand%0d_beat%0d: got %h last=%b want %h last=%b", r, i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
                else n_pass++;
            end
            n_total++; if (frame_cnt !== model_frames) $display("FAIL rand%0d_frame_cnt: got %0d want %0d", r, frame_cnt, model_frames); else n_pass++;
            n_total++; if (cmd_cnt !== model_cmds) $display("FAIL rand%0d_cmd_cnt: got %0d want %0d", r, cmd_cnt, model_cmds); else n_pass++;
        end
        ready_mode = 0;
    endtask

    initial begin
        rst = 1'b1;
        model_frames = 32'h0;
        model_cmds   = 32'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timer_restart();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
